// File: rtl/gshare_bht_pkg.sv
// Shared types and constants for the gshare branch history table.
// Struct field widths follow the default configuration below.
package gshare_bht_pkg;

    localparam int unsigned BhtVlen      = 64;
    localparam int unsigned BhtNrEntries = 1024;
    localparam int unsigned BhtIpf       = 2;
    localparam int unsigned BhtCtrBits   = 2;
    localparam int unsigned BhtGhrBits   = 8;
    localparam int unsigned BhtIdxBits   = $clog2(BhtNrEntries);

    typedef logic [BhtCtrBits-1:0] ctr_t;

    // Weakly-not-taken: the largest value whose MSB is still 0.
    function automatic logic [3:0] wnt_init(input int unsigned bits);
        return 4'((1 << (bits - 1)) - 1);
    endfunction

    localparam ctr_t WNT_INIT = ctr_t'(wnt_init(BhtCtrBits));

    typedef struct packed {
        logic [BhtIdxBits-1:0] index;
    } bp_metadata_t;

    typedef struct packed {
        logic               valid;
        logic [BhtVlen-1:0] pc;
        logic               taken;
        bp_metadata_t       metadata;
    } bht_update_t;

    typedef struct packed {
        logic         valid;
        logic         taken;
        bp_metadata_t metadata;
    } bht_prediction_t;

    typedef enum logic [0:0] {
        StSweep,
        StReady
    } bht_state_e;

endpackage

// File: rtl/gshare_bht_ram.sv
// Counter storage: flop array, two asynchronous row reads, one synchronous row write
// with per-column enables.
module gshare_bht_ram #(
    parameter int unsigned NrRows   = 512,
    parameter int unsigned Cols     = 2,
    parameter int unsigned CtrBits  = 2,
    parameter int unsigned AddrBits = $clog2(NrRows)
) (
    input  logic                             clk_i,
    input  logic [AddrBits-1:0]              rd_a_addr_i,
    output logic [Cols-1:0][CtrBits-1:0]     rd_a_data_o,
    input  logic [AddrBits-1:0]              rd_b_addr_i,
    output logic [Cols-1:0][CtrBits-1:0]     rd_b_data_o,
    input  logic [Cols-1:0]                  wr_en_i,
    input  logic [AddrBits-1:0]              wr_addr_i,
    input  logic [Cols-1:0][CtrBits-1:0]     wr_data_i
);

    logic [Cols-1:0][CtrBits-1:0] mem_q [NrRows];

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < int'(Cols); c++) begin
            if (wr_en_i[c]) begin
                mem_q[wr_addr_i][c] <= wr_data_i[c];
            end
        end
    end

    assign rd_a_data_o = mem_q[rd_a_addr_i];
    assign rd_b_data_o = mem_q[rd_b_addr_i];

endmodule

// File: rtl/gshare_bht.sv
// Gshare branch history table: PC row bits XOR global history select a row of saturating
// counters; a self-timed sweep initialises the table after reset or flush.
module gshare_bht
    import gshare_bht_pkg::*;
#(
    parameter int unsigned NR_ENTRIES      = BhtNrEntries,
    parameter int unsigned INSTR_PER_FETCH = BhtIpf,
    parameter int unsigned CTR_BITS        = BhtCtrBits,
    parameter int unsigned GHR_BITS        = BhtGhrBits,
    parameter int unsigned VLEN            = BhtVlen
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_bp_i,
    input  logic            debug_mode_i,
    input  logic [VLEN-1:0] vpc_i,
    input  bht_update_t     bht_update_i,
    output bht_prediction_t bht_prediction_o [INSTR_PER_FETCH],
    output logic            init_done_o
);

    localparam int unsigned IdxBits = $clog2(NR_ENTRIES);
    localparam int unsigned ColBits = $clog2(INSTR_PER_FETCH);
    localparam int unsigned RowBits = IdxBits - ColBits;
    localparam int unsigned NrRows  = NR_ENTRIES / INSTR_PER_FETCH;

    localparam logic [RowBits-1:0]  LastRow = RowBits'(NrRows - 1);
    localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'(wnt_init(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CtrMax  = '1;

    typedef logic [INSTR_PER_FETCH-1:0][CTR_BITS-1:0] row_t;

    bht_state_e          state_q, state_d;
    logic [RowBits-1:0]  sweep_ptr_q, sweep_ptr_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    logic [RowBits-1:0]         pred_row, upd_row, wr_row;
    logic [ColBits-1:0]         upd_col;
    logic [IdxBits-1:0]         upd_idx;
    row_t                       pred_rdata, upd_rdata, wr_data;
    logic [INSTR_PER_FETCH-1:0] wr_en;
    logic [CTR_BITS-1:0]        upd_ctr_old, upd_ctr_new;
    logic                       upd_accept;

    // vpc_i and the update PC are only partly used by the hash.
    logic unused_bits;
    assign unused_bits = ^{vpc_i, bht_update_i.pc};

    assign pred_row = vpc_i[1+ColBits +: RowBits] ^ RowBits'(ghr_q);
    assign upd_idx  = IdxBits'(bht_update_i.metadata.index);
    assign upd_row  = upd_idx[IdxBits-1:ColBits];
    assign upd_col  = upd_idx[ColBits-1:0];

    assign upd_accept = bht_update_i.valid && (state_q == StReady) && !debug_mode_i
                        && !flush_bp_i;

    gshare_bht_ram #(
        .NrRows  (NrRows),
        .Cols    (INSTR_PER_FETCH),
        .CtrBits (CTR_BITS)
    ) u_ram (
        .clk_i       (clk_i),
        .rd_a_addr_i (pred_row),
        .rd_a_data_o (pred_rdata),
        .rd_b_addr_i (upd_row),
        .rd_b_data_o (upd_rdata),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_row),
        .wr_data_i   (wr_data)
    );

    assign upd_ctr_old = upd_rdata[upd_col];

    always_comb begin
        upd_ctr_new = upd_ctr_old;
        if (bht_update_i.taken) begin
            if (upd_ctr_old != CtrMax) upd_ctr_new = upd_ctr_old + 1'b1;
        end else begin
            if (upd_ctr_old != '0) upd_ctr_new = upd_ctr_old - 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        ghr_d       = ghr_q;
        wr_en       = '0;
        wr_row      = sweep_ptr_q;
        wr_data     = {INSTR_PER_FETCH{CtrInit}};
        unique case (state_q)
            StSweep: begin
                wr_en = '1;
                if (sweep_ptr_q == LastRow) begin
                    sweep_ptr_d = '0;
                    state_d     = StReady;
                end else begin
                    sweep_ptr_d = sweep_ptr_q + 1'b1;
                end
            end
            StReady: begin
                if (upd_accept) begin
                    wr_en[upd_col] = 1'b1;
                    wr_row         = upd_row;
                    wr_data        = {INSTR_PER_FETCH{upd_ctr_new}};
                    ghr_d          = GHR_BITS'({ghr_q, bht_update_i.taken});
                end
            end
            default: ;
        endcase
        // Flush overrides everything, including an update in the same cycle.
        if (flush_bp_i) begin
            state_d     = StSweep;
            sweep_ptr_d = '0;
            ghr_d       = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StSweep;
            sweep_ptr_q <= '0;
            ghr_q       <= '0;
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
            ghr_q       <= ghr_d;
        end
    end

    assign init_done_o = (state_q == StReady);

    for (genvar i = 0; i < int'(INSTR_PER_FETCH); i++) begin : gen_pred
        assign bht_prediction_o[i].valid          = (state_q == StReady);
        assign bht_prediction_o[i].taken          = pred_rdata[i][CTR_BITS-1];
        assign bht_prediction_o[i].metadata.index = BhtIdxBits'({pred_row, ColBits'(i)});
    end

endmodule

// File: tb/tb_gshare_bht.sv
// Self-checking bench for gshare_bht: randomized updates against a behavioural table model.
module tb_gshare_bht;
    import gshare_bht_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            dbg = 1'b0;
    logic [63:0]     vpc = '0;
    bht_update_t     upd;
    bht_prediction_t pred [2];
    logic            init_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain counters, ready flag, cycles left in the sweep, history.
    int         m_ctr [1024];
    bit         m_ready = 1'b0;
    int         m_left  = 512;
    logic [7:0] m_ghr   = '0;

    always #5 clk = ~clk;

    gshare_bht dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_bp_i       (flush),
        .debug_mode_i     (dbg),
        .vpc_i            (vpc),
        .bht_update_i     (upd),
        .bht_prediction_o (pred),
        .init_done_o      (init_done)
    );

    function automatic logic [8:0] m_row();
        return vpc[10:2] ^ {1'b0, m_ghr};
    endfunction

    function automatic logic [9:0] m_idx(input int s);
        return {m_row(), s[0]};
    endfunction

    function automatic logic m_taken(input int s);
        return m_ctr[m_idx(s)] >= 2;
    endfunction

    // A fetch PC whose hashed row equals r under the model's current history.
    function automatic logic [63:0] vpc_for_row(input logic [8:0] r);
        logic [63:0] v;
        v = {$urandom, $urandom};
        v[10:2] = r ^ {1'b0, m_ghr};
        return v;
    endfunction

    task automatic drive_upd(input int idx, input bit taken, input bit valid);
        upd.valid          = valid;
        upd.pc             = {$urandom, $urandom};
        upd.taken          = taken;
        upd.metadata.index = 10'(idx);
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic step();
        if (rst || flush) begin
            m_ready = 1'b0;
            m_left  = 512;
            m_ghr   = '0;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < 1024; i++) m_ctr[i] = 1;
            end
        end else if (upd.valid && !dbg) begin
            if (upd.taken && m_ctr[upd.metadata.index] < 3) m_ctr[upd.metadata.index]++;
            if (!upd.taken && m_ctr[upd.metadata.index] > 0) m_ctr[upd.metadata.index]--;
            m_ghr = {m_ghr[6:0], upd.taken};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] pcs [3];
        pcs[0] = 64'h0;
        pcs[1] = 64'h1000;
        pcs[2] = 64'hFFFC;
        rst = 1'b1;
        upd = '0;
        #2;
        n_tests++;
        if (init_done !== 1'b0 || pred[0].valid !== 1'b0 || pred[1].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: init_done=%b valid=%b%b, want 0 00", init_done,
                     pred[0].valid, pred[1].valid);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 512; c++) begin
            n_tests++;
            if (init_done !== 1'b0 || pred[0].valid !== 1'b0 || pred[1].valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_sweep cycle %0d: init_done=%b valid=%b%b, want 0 00", c,
                         init_done, pred[0].valid, pred[1].valid);
            end
            step();
        end
        n_tests++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_done: init_done=%b, want 1", init_done);
        end
        for (int p = 0; p < 3; p++) begin
            vpc = pcs[p];
            #1;
            for (int s = 0; s < 2; s++) begin
                n_tests++;
                if (pred[s].valid !== 1'b1 || pred[s].taken !== 1'b0 ||
                    pred[s].metadata.index !== m_idx(s)) begin
                    n_fail++;
                    $display("FAIL reset_pred vpc=%h slot%0d: got v=%b t=%b idx=%0d, want 1 0 %0d",
                             vpc, s, pred[s].valid, pred[s].taken, pred[s].metadata.index,
                             m_idx(s));
                end
            end
        end
    endtask

    task automatic test_ghr();
        drive_upd(100, 1'b1, 1'b1);
        step();
        upd.valid = 1'b0;
        vpc = {$urandom, $urandom};
        vpc[10:2] = '0;
        #1;
        for (int s = 0; s < 2; s++) begin
            n_tests++;
            if (pred[s].metadata.index !== 10'(2 + s) || pred[s].taken !== m_taken(s)) begin
                n_fail++;
                $display("FAIL ghr_shift slot%0d: got idx=%0d t=%b, want idx=%0d t=%b", s,
                         pred[s].metadata.index, pred[s].taken, 2 + s, m_taken(s));
            end
        end
    endtask

    task automatic test_saturation();
        bit seq [9];
        seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 9; k++) begin
            drive_upd(5, seq[k], 1'b1);
            vpc = vpc_for_row(9'd2);
            #1;
            // Same-cycle prediction sees the pre-update counter.
            n_tests++;
            if (pred[1].taken !== m_taken(1)) begin
                n_fail++;
                $display("FAIL sat_same_cycle step %0d: got t=%b, want t=%b", k, pred[1].taken,
                         m_taken(1));
            end
            step();
            upd.valid = 1'b0;
            vpc = vpc_for_row(9'd2);
            #1;
            n_tests++;
            if (pred[1].taken !== m_taken(1) || pred[1].metadata.index !== 10'd5) begin
                n_fail++;
                $display("FAIL sat_after step %0d: got t=%b idx=%0d, want t=%b idx=5 (ctr %0d)",
                         k, pred[1].taken, pred[1].metadata.index, m_taken(1), m_ctr[5]);
            end
        end
    endtask

    task automatic test_debug();
        dbg = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_upd(7, 1'b1, 1'b1);
            step();
        end
        upd.valid = 1'b0;
        vpc = vpc_for_row(9'd3);
        #1;
        n_tests++;
        if (pred[1].taken !== 1'b0 || pred[1].metadata.index !== 10'd7) begin
            n_fail++;
            $display("FAIL debug_ignore: got t=%b idx=%0d, want t=0 idx=7", pred[1].taken,
                     pred[1].metadata.index);
        end
        dbg = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_upd(7, k == 0, 1'b1);
            step();
            upd.valid = 1'b0;
            vpc = vpc_for_row(9'd3);
            #1;
            n_tests++;
            if (pred[1].taken !== m_taken(1) || pred[1].metadata.index !== 10'd7) begin
                n_fail++;
                $display("FAIL debug_after %0d: got t=%b idx=%0d, want t=%b idx=7", k,
                         pred[1].taken, pred[1].metadata.index, m_taken(1));
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive_upd(($urandom % 4 == 0) ? int'($urandom % 1024) : int'($urandom % 16),
                      $urandom % 2 == 1, $urandom % 2 == 1);
            dbg = ($urandom % 8 == 0);
            vpc = ($urandom % 2 == 0) ? vpc_for_row(9'($urandom % 8)) : {$urandom, $urandom};
            #1;
            for (int s = 0; s < 2; s++) begin
                n_tests++;
                if (pred[s].valid !== 1'b1 || pred[s].taken !== m_taken(s) ||
                    pred[s].metadata.index !== m_idx(s)) begin
                    n_fail++;
                    $display("FAIL random %0d slot%0d: got v=%b t=%b idx=%0d, want 1 %b %0d", k,
                             s, pred[s].valid, pred[s].taken, pred[s].metadata.index,
                             m_taken(s), m_idx(s));
                end
            end
            step();
        end
        dbg = 1'b0;
        upd.valid = 1'b0;
    endtask

    task automatic test_flush();
        drive_upd(5, 1'b1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int c = 0; c < 100; c++) begin
            drive_upd(int'($urandom % 1024), 1'b1, 1'b1);
            n_tests++;
            if (init_done !== 1'b0 || pred[0].valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_sweep %0d: init_done=%b valid=%b, want 0 0", c, init_done,
                         pred[0].valid);
            end
            step();
        end
        drive_upd(9, 1'b1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        upd.valid = 1'b0;
        for (int c = 0; c < 512; c++) begin
            n_tests++;
            if (init_done !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_restart %0d: init_done=%b, want 0", c, init_done);
            end
            step();
        end
        vpc = {$urandom, $urandom};
        vpc[10:2] = '0;
        #1;
        n_tests++;
        if (init_done !== 1'b1 || pred[0].metadata.index !== 10'd0 ||
            pred[1].metadata.index !== 10'd1 || pred[0].taken !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done: init_done=%b idx=%0d/%0d t=%b, want 1 0/1 0", init_done,
                     pred[0].metadata.index, pred[1].metadata.index, pred[0].taken);
        end
    endtask

    task automatic test_reset_mid_sweep();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (300) step();
        rst = 1'b1;
        #1;
        n_tests++;
        if (init_done !== 1'b0 || pred[1].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_assert: init_done=%b valid=%b, want 0 0", init_done,
                     pred[1].valid);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 512; c++) begin
            n_tests++;
            if (init_done !== 1'b0 || pred[0].valid !== 1'b0 || pred[1].valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_sweep %0d: init_done=%b valid=%b%b, want 0 00", c,
                         init_done, pred[0].valid, pred[1].valid);
            end
            step();
        end
        vpc = {$urandom, $urandom};
        #1;
        for (int s = 0; s < 2; s++) begin
            n_tests++;
            if (pred[s].valid !== 1'b1 || pred[s].taken !== 1'b0 ||
                pred[s].metadata.index !== m_idx(s)) begin
                n_fail++;
                $display("FAIL midreset_done slot%0d: got v=%b t=%b idx=%0d, want 1 0 %0d", s,
                         pred[s].valid, pred[s].taken, pred[s].metadata.index, m_idx(s));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ghr();
        test_saturation();
        test_debug();
        test_random();
        test_flush();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
